// File: rtl/adc_cap_pkg.sv
// Shared definitions for the ADC capture buffer readback path: width
// defaults, buffer depth and the reader FSM state encoding.
package adc_cap_pkg;

    localparam int AW_DEF    = 15;
    localparam int DW_DEF    = 9;
    localparam int LW_DEF    = 16;
    localparam int CAP_DEPTH = 2 ** AW_DEF;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DRAIN
    } rd_state_e;

endpackage

// File: rtl/adc_capture_sram_reader_if.sv
// Bundles the sample stream (valid/ready) and the capture SRAM port.
// The master modport is the reader; the slave modport is the consumer/SRAM side.
interface adc_capture_sram_reader_if
    import adc_cap_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          CEB;
    logic          WEB;
    logic [AW-1:0] A;
    logic [DW-1:0] Q;

    modport master (
        output out_valid, out_data, out_last, CEB, WEB, A,
        input  out_ready, Q
    );

    modport slave (
        input  out_valid, out_data, out_last, CEB, WEB, A,
        output out_ready, Q
    );
endinterface

// File: rtl/adc_cap_rd_fifo.sv
// Two-entry FIFO of {last, data}. Entry 0 is always the head, so the
// head outputs are plain registers and hold steady until popped.
module adc_cap_rd_fifo
    import adc_cap_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic          in_last,
    input  logic [DW-1:0] in_data,
    output logic [1:0]    count,
    output logic          head_last,
    output logic [DW-1:0] head_data
);
    logic [DW:0] e0;
    logic [DW:0] e1;

    assign head_last = e0[DW];
    assign head_data = e0[DW-1:0];

    // Entry storage and occupancy; a push into a full FIFO cannot occur because the reader never over-issues
    always_ff @(posedge CLK) begin
        if (RST) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= {in_last, in_data};
                    else               e1 <= {in_last, in_data};
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0 <= {in_last, in_data};
                    end else begin
                        e0 <= e1;
                        e1 <= {in_last, in_data};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/adc_capture_sram_reader.sv
// Readback engine for the circular ADC capture SRAM: reads a window of
// rd_len samples from start_addr and streams them out over valid/ready.
// Optional RD_BEAT_CNT_EN adds a beat_cnt output counting accepted beats.
//
// state    | meaning
// RD_IDLE  | no job; waiting for start
// RD_RUN   | reads still to issue
// RD_DRAIN | all reads issued; waiting for the last beat to be accepted
module adc_capture_sram_reader
    import adc_cap_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [LW-1:0] rd_len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
`ifdef RD_BEAT_CNT_EN
    output logic [LW-1:0] beat_cnt,
`endif
    adc_capture_sram_reader_if.master bus
);
    rd_state_e     state, state_nxt;
    logic [AW-1:0] addr;
    logic [LW-1:0] remaining;
    logic          inflight;
    logic          inflight_last;
    logic          zero_done;
    logic          issue;
    logic          start_ok;
    logic          fifo_pop;
    logic          fifo_push;
    logic [1:0]    fifo_count;
    logic [1:0]    credit;
    logic          head_last;
    logic [DW-1:0] head_data;

    // Slots already spoken for: queued beats plus the read whose data lands next cycle.
    // A beat leaving this cycle frees its slot in time for a new issue, giving 1 sample/cycle.
    assign credit    = fifo_count + {1'b0, inflight};
    assign fifo_pop  = bus.out_valid & bus.out_ready;
    assign fifo_push = inflight & ~abort;

    assign busy          = (state != RD_IDLE);
    assign bus.out_valid = (fifo_count != 2'd0);
    assign bus.out_data  = head_data;
    assign bus.out_last  = head_last;
    assign bus.CEB       = ~issue;
    assign bus.WEB       = 1'b1;
    assign bus.A         = addr;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= RD_IDLE;
        else     state <= state_nxt;
    end

    // Next-state, read issue and done; abort and reset silence everything
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        start_ok  = 1'b0;
        done      = 1'b0;
        if (RST || abort) begin
            state_nxt = RD_IDLE;
        end else begin
            if (zero_done) done = 1'b1;
            case (state)
                RD_IDLE: begin
                    if (start) begin
                        start_ok = 1'b1;
                        if (rd_len != '0) state_nxt = RD_RUN;
                    end
                end
                RD_RUN: begin
                    if ((remaining != '0) && ((credit != 2'd2) || fifo_pop)) begin
                        issue = 1'b1;
                        if (remaining == LW'(1)) state_nxt = RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (fifo_pop && head_last) begin
                        done      = 1'b1;
                        state_nxt = RD_IDLE;
                    end
                end
                default: state_nxt = RD_IDLE;
            endcase
        end
    end

    // Address/length counters and the one-cycle read-latency tracker
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            zero_done     <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (remaining == LW'(1));
            zero_done     <= start_ok && (rd_len == '0);
            if (start_ok) begin
                addr      <= start_addr;
                remaining <= rd_len;
            end else if (issue) begin
                addr      <= addr + AW'(1);
                remaining <= remaining - LW'(1);
            end
        end
    end

`ifdef RD_BEAT_CNT_EN
    // Accepted-beat counter; left untouched by done/abort so firmware can read it afterwards
    always_ff @(posedge CLK) begin
        if (RST)           beat_cnt <= '0;
        else if (start_ok) beat_cnt <= '0;
        else if (fifo_pop) beat_cnt <= beat_cnt + LW'(1);
    end
`endif

    adc_cap_rd_fifo #(.DW(DW)) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (abort),
        .in_last   (inflight_last),
        .in_data   (bus.Q),
        .count     (fifo_count),
        .head_last (head_last),
        .head_data (head_data)
    );
endmodule
